reg_rename_file: RTL and testbench
==================================

// Module: reg_rename_file
// PURPOSE
//  Architectural register file plus rename table; consumer of the ROB commit port (rob_set_*).
//  Issue renames rd to its ROB tag; commit writes values and releases a rename when tags match.
//  Answers the Decoder's two operand queries combinationally: value, or pending ROB tag.
//  Flushes all renames on ROB clear.
// PARAMETERS
//  REG_NUM       32  number of architectural registers (x0 hardwired 0)
//  ROB_SIZE_BIT   4  ROB tag width; default comes from `ROB_SIZE_BIT in config.v
// PORTS
//  clk_in           in   1   system clock; all state updates on posedge
//  rst_in           in   1   synchronous, active-high reset
//  rdy_in           in   1   when low: no state change; combinational outputs remain valid
//  clear            in   1   ROB flush (branch mispredict); acts only when rdy_in=1
//  rob_set_idx      in   5   commit dest reg; 0 = no commit this cycle
//  rob_set_reg_val  in   32  commit value
//  rob_set_recorder in   RSB ROB tag of committing entry
//  dec_set_idx      in   5   issue dest reg to rename; 0 = no rename
//  dec_set_dep      in   RSB ROB tag (ROB tail) assigned to that rd
//  query_idx1/2     in   5   source register numbers
//  query_has_dep1/2 out  1   1 = operand pending in ROB
//  query_dep1/2     out  RSB pending ROB tag (0 when has_dep=0)
//  query_val1/2     out  32  register value (0 when has_dep=1)
// BEHAVIOUR
//  State per reg: val[31:0], busy, dep[RSB-1:0]. Reset: all val=0, busy=0, dep=0.
//  Priority on posedge: rst_in > !rdy_in (hold) > clear > normal update.
//  clear&&rdy_in: all busy<=0, dep<=0; val unchanged; that cycle's commit and rename are ignored
//   (ROB may present a wrong-path commit while flushing).
//  Normal cycle, commit (rob_set_idx!=0): val[idx]<=rob_set_reg_val unconditionally;
//   busy[idx]<=0 only if busy[idx] && dep[idx]==rob_set_recorder.
//  Normal cycle, rename (dec_set_idx!=0): busy<=1, dep<=dec_set_dep.
//  Same reg committed and renamed in one cycle: rename wins busy/dep; val still written.
//  x0: writes and renames ignored; queries of x0 always return has_dep=0, val=0.
//  Query (combinational, 0-cycle):
//   if !busy[q]: has_dep=0, val=val[q].
//   elif commit this cycle with idx==q, recorder==dep[q], rdy_in=1, !clear:
//    has_dep=0, val=rob_set_reg_val (forwarding).
//   else: has_dep=1, dep=dep[q], val=0.
//  Queries see pre-rename state: same-cycle rename never affects that cycle's answers
//   (rs read before rd rename for one instruction, e.g. addi x5,x5,1).
//  Stale commit (tag mismatch) writes val only; rename stays busy. Tags are not range-checked.
// STRUCTURE
//  Shared in config.v: `ROB_SIZE_BIT, register-count macro.
//  One sub-module: reg_query_port (one query channel incl. forwarding), instantiated twice.
//  Remaining state is flat arrays in this module; no FSM beyond the busy/dep bits.
// TESTING
//  1 reset, query x3 -> has_dep=0, val=0; commit x3=0xDEAD tag2 -> next cycle query x3 val=0xDEAD.
//  2 rename x5->tag4; query x5 -> has_dep=1, dep=4; commit x5 tag4 val=7 -> same-cycle forward val=7,
//    next cycle busy=0.
//  3 rename x5->tag4, then x5->tag6; commit x5 tag4 val=9 -> val=9 written, still has_dep=1, dep=6.
//  4 same cycle: commit x7 tag1 and rename x7->tag3 -> next cycle has_dep=1, dep=3; after commit
//    tag3 val=0x10 -> val=0x10.
//  5 rename x1,x2,x3; assert clear with concurrent commit x1 val=0x55 -> all busy=0; x1 val unchanged.
//  6 rdy_in=0 during commit x4 val=1 and rename x6 -> no change; x0 rename/commit -> query x0
//    has_dep=0, val=0.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// reg_rename_file_pkg: shared sizes for the register file and rename table
// Exports register count, index width, data width and ROB tag width.
package reg_rename_file_pkg;
  localparam int REG_NUM = 32;
  localparam int IDX_W = 5;
  localparam int XLEN = 32;
  localparam int ROB_SIZE_BIT = 4;
endpackage

// File: rtl/reg_query_port.sv
// reg_query_port: one operand lookup channel with same-cycle commit forwarding
// Ports: busy/dep/val are the whole rename/register state; commit, set_idx,
// set_recorder, set_val describe this cycle's effective commit; idx is the
// queried register; has_dep/pend_dep/value are the combinational answer.
module reg_query_port
  import reg_rename_file_pkg::*;
#(
  parameter int RSB = ROB_SIZE_BIT
) (
  input  logic [REG_NUM-1:0]          busy,
  input  logic [REG_NUM-1:0][RSB-1:0] dep,
  input  logic [REG_NUM-1:0][XLEN-1:0] val,
  input  logic                        commit,
  input  logic [IDX_W-1:0]            set_idx,
  input  logic [RSB-1:0]              set_recorder,
  input  logic [XLEN-1:0]             set_val,
  input  logic [IDX_W-1:0]            idx,
  output logic                        has_dep,
  output logic [RSB-1:0]              pend_dep,
  output logic [XLEN-1:0]             value
);
  logic b;
  logic fwd;
  // x0 is never renamed or written, so it naturally reads as ready with value 0
  always_comb begin
    b = busy[idx];
    fwd = commit && set_idx == idx && set_recorder == dep[idx];
    has_dep = b && !fwd;
    pend_dep = has_dep ? dep[idx] : '0;
    value = !b ? val[idx] : fwd ? set_val : '0;
  end
endmodule

// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file plus ROB rename table
// Ports: clk_in/rst_in (sync active-high)/rdy_in (low = hold) control updates;
// clear flushes all renames; rob_set_* is the ROB commit port; dec_set_* renames
// an issued rd to its ROB tag; query_idx1/2 are answered combinationally with
// query_has_dep, query_dep and query_val.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int RSB = ROB_SIZE_BIT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic [IDX_W-1:0] rob_set_idx,
  input  logic [XLEN-1:0]  rob_set_reg_val,
  input  logic [RSB-1:0]   rob_set_recorder,
  input  logic [IDX_W-1:0] dec_set_idx,
  input  logic [RSB-1:0]   dec_set_dep,
  input  logic [IDX_W-1:0] query_idx1,
  input  logic [IDX_W-1:0] query_idx2,
  output logic             query_has_dep1,
  output logic             query_has_dep2,
  output logic [RSB-1:0]   query_dep1,
  output logic [RSB-1:0]   query_dep2,
  output logic [XLEN-1:0]  query_val1,
  output logic [XLEN-1:0]  query_val2
);
  logic [REG_NUM-1:0]           busy;
  logic [REG_NUM-1:0][RSB-1:0]  dep;
  logic [REG_NUM-1:0][XLEN-1:0] val;
  logic commit;
  assign commit = rdy_in && !clear && rob_set_idx != '0;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= '0;
      dep <= '0;
      val <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        busy <= '0;
        dep <= '0;
      end else begin
        if (rob_set_idx != '0) begin
          val[rob_set_idx] <= rob_set_reg_val;
          if (busy[rob_set_idx] && dep[rob_set_idx] == rob_set_recorder) busy[rob_set_idx] <= 1'b0;
        end
        // placed after the commit so a same-register rename overrides the release
        if (dec_set_idx != '0) begin
          busy[dec_set_idx] <= 1'b1;
          dep[dec_set_idx] <= dec_set_dep;
        end
      end
    end
  end
  reg_query_port #(.RSB(RSB)) q1 (
    .busy(busy), .dep(dep), .val(val), .commit(commit), .set_idx(rob_set_idx),
    .set_recorder(rob_set_recorder), .set_val(rob_set_reg_val), .idx(query_idx1),
    .has_dep(query_has_dep1), .pend_dep(query_dep1), .value(query_val1)
  );
  reg_query_port #(.RSB(RSB)) q2 (
    .busy(busy), .dep(dep), .val(val), .commit(commit), .set_idx(rob_set_idx),
    .set_recorder(rob_set_recorder), .set_val(rob_set_reg_val), .idx(query_idx2),
    .has_dep(query_has_dep2), .pend_dep(query_dep2), .value(query_val2)
  );
endmodule

// File: tb/tb_reg_rename_file.sv
// tb_reg_rename_file: directed and randomized checks of reg_rename_file against a behavioural model
module tb_reg_rename_file;
  logic clk_in = 0;
  logic rst_in, rdy_in, clear;
  logic [4:0] rob_set_idx, dec_set_idx, query_idx1, query_idx2;
  logic [31:0] rob_set_reg_val;
  logic [3:0] rob_set_recorder, dec_set_dep;
  logic query_has_dep1, query_has_dep2;
  logic [3:0] query_dep1, query_dep2;
  logic [31:0] query_val1, query_val2;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_val [32];
  logic m_busy [32];
  logic [3:0] m_dep [32];

  reg_rename_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .rob_set_idx(rob_set_idx), .rob_set_reg_val(rob_set_reg_val), .rob_set_recorder(rob_set_recorder),
    .dec_set_idx(dec_set_idx), .dec_set_dep(dec_set_dep),
    .query_idx1(query_idx1), .query_idx2(query_idx2),
    .query_has_dep1(query_has_dep1), .query_has_dep2(query_has_dep2),
    .query_dep1(query_dep1), .query_dep2(query_dep2),
    .query_val1(query_val1), .query_val2(query_val2)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_query(input logic [4:0] q, output logic h, output logic [3:0] d, output logic [31:0] v);
    h = 0;
    d = 0;
    v = 0;
    if (q == 0) return;
    if (!m_busy[q]) v = m_val[q];
    else if (rdy_in && !clear && rob_set_idx == q && rob_set_recorder == m_dep[q]) v = rob_set_reg_val;
    else begin
      h = 1;
      d = m_dep[q];
    end
  endfunction

  function automatic void model_clock();
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0;
        m_busy[i] = 0;
        m_dep[i] = 0;
      end
    end else if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 0;
          m_dep[i] = 0;
        end
      end else begin
        if (rob_set_idx != 0) begin
          if (m_busy[rob_set_idx] && m_dep[rob_set_idx] == rob_set_recorder) m_busy[rob_set_idx] = 0;
          m_val[rob_set_idx] = rob_set_reg_val;
        end
        if (dec_set_idx != 0) begin
          m_busy[dec_set_idx] = 1;
          m_dep[dec_set_idx] = dec_set_dep;
        end
      end
    end
  endfunction

  task automatic run_cycle();
    logic h;
    logic [3:0] d;
    logic [31:0] v;
    @(negedge clk_in);
    model_query(query_idx1, h, d, v);
    chk("q1_has_dep", 32'(query_has_dep1), 32'(h));
    chk("q1_dep", 32'(query_dep1), 32'(d));
    chk("q1_val", query_val1, v);
    model_query(query_idx2, h, d, v);
    chk("q2_has_dep", 32'(query_has_dep2), 32'(h));
    chk("q2_dep", 32'(query_dep2), 32'(d));
    chk("q2_val", query_val2, v);
    @(posedge clk_in);
    model_clock();
    #1;
  endtask

  task automatic idle();
    clear = 0;
    rob_set_idx = 0;
    rob_set_reg_val = 0;
    rob_set_recorder = 0;
    dec_set_idx = 0;
    dec_set_dep = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 0;
      m_busy[i] = 0;
      m_dep[i] = 0;
    end
    rst_in = 1;
    rdy_in = 1;
    query_idx1 = 0;
    query_idx2 = 0;
    idle();
    @(posedge clk_in);
    #1;
    run_cycle();
    rst_in = 0;
    // reset state and plain commit
    query_idx1 = 3;
    #2;
    chk("t1_reset_has_dep", 32'(query_has_dep1), 0);
    chk("t1_reset_val", query_val1, 0);
    rob_set_idx = 3; rob_set_reg_val = 32'hDEAD; rob_set_recorder = 2;
    run_cycle();
    idle();
    #2;
    chk("t1_commit_val", query_val1, 32'hDEAD);
    // rename then matching commit with forwarding
    dec_set_idx = 5; dec_set_dep = 4;
    run_cycle();
    idle();
    query_idx1 = 5;
    #2;
    chk("t2_has_dep", 32'(query_has_dep1), 1);
    chk("t2_dep", 32'(query_dep1), 4);
    rob_set_idx = 5; rob_set_reg_val = 7; rob_set_recorder = 4;
    #1;
    chk("t2_fwd_has_dep", 32'(query_has_dep1), 0);
    chk("t2_fwd_val", query_val1, 7);
    run_cycle();
    idle();
    #2;
    chk("t2_after_has_dep", 32'(query_has_dep1), 0);
    chk("t2_after_val", query_val1, 7);
    // stale commit keeps the newer rename
    dec_set_idx = 5; dec_set_dep = 4;
    run_cycle();
    dec_set_dep = 6;
    run_cycle();
    idle();
    rob_set_idx = 5; rob_set_reg_val = 9; rob_set_recorder = 4;
    run_cycle();
    idle();
    #2;
    chk("t3_has_dep", 32'(query_has_dep1), 1);
    chk("t3_dep", 32'(query_dep1), 6);
    chk("t3_val_hidden", query_val1, 0);
    clear = 1;
    run_cycle();
    idle();
    #2;
    chk("t3_val_written", query_val1, 9);
    // commit and rename of the same reg in one cycle
    query_idx1 = 7;
    rob_set_idx = 7; rob_set_reg_val = 32'h20; rob_set_recorder = 1;
    dec_set_idx = 7; dec_set_dep = 3;
    run_cycle();
    idle();
    #2;
    chk("t4_has_dep", 32'(query_has_dep1), 1);
    chk("t4_dep", 32'(query_dep1), 3);
    rob_set_idx = 7; rob_set_reg_val = 32'h10; rob_set_recorder = 3;
    run_cycle();
    idle();
    #2;
    chk("t4_val", query_val1, 32'h10);
    // flush with a concurrent wrong-path commit
    for (int r = 1; r <= 3; r++) begin
      dec_set_idx = 5'(r); dec_set_dep = 4'(r);
      run_cycle();
    end
    idle();
    query_idx1 = 1; query_idx2 = 2;
    clear = 1; rob_set_idx = 1; rob_set_reg_val = 32'h55; rob_set_recorder = 1;
    run_cycle();
    idle();
    #2;
    chk("t5_x1_has_dep", 32'(query_has_dep1), 0);
    chk("t5_x1_val", query_val1, 0);
    chk("t5_x2_has_dep", 32'(query_has_dep2), 0);
    query_idx1 = 3;
    #1;
    chk("t5_x3_val", query_val1, 32'hDEAD);
    // hold while not ready, then x0 immunity
    rdy_in = 0;
    rob_set_idx = 4; rob_set_reg_val = 1; rob_set_recorder = 0;
    dec_set_idx = 6; dec_set_dep = 5;
    run_cycle();
    rdy_in = 1;
    idle();
    query_idx1 = 4; query_idx2 = 6;
    #2;
    chk("t6_x4_val", query_val1, 0);
    chk("t6_x6_has_dep", 32'(query_has_dep2), 0);
    dec_set_idx = 0; rob_set_idx = 0;
    dec_set_dep = 2; rob_set_reg_val = 32'hFF;
    query_idx1 = 0;
    run_cycle();
    #2;
    chk("t6_x0_has_dep", 32'(query_has_dep1), 0);
    chk("t6_x0_val", query_val1, 0);
    // randomized traffic over a few registers and tags to force collisions
    for (int n = 0; n < 3000; n++) begin
      rst_in = ($urandom_range(0, 299) == 0);
      rdy_in = ($urandom_range(0, 99) < 85);
      clear = ($urandom_range(0, 99) < 5);
      rob_set_idx = 5'($urandom_range(0, 7));
      rob_set_reg_val = $urandom;
      rob_set_recorder = 4'($urandom_range(0, 15));
      dec_set_idx = 5'($urandom_range(0, 7));
      dec_set_dep = 4'($urandom_range(0, 15));
      query_idx1 = 5'($urandom_range(0, 8));
      query_idx2 = ($urandom_range(0, 3) == 0) ? rob_set_idx : 5'($urandom_range(0, 8));
      run_cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
